// File: rtl/gf163_pkg.sv
// rtl/gf163_pkg.sv - GF(2^163) field constants, FSM state type and helpers
package gf163_pkg;

    localparam int M      = 163;
    localparam int PROD_W = 2 * M - 1;

    // p(x) = x^163 + x^80 + x^47 + x^9 + 1, consumed by the downstream reducer
    localparam int RED_K1 = 80;
    localparam int RED_K2 = 47;
    localparam int RED_K3 = 9;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    function automatic int ceil_div(input int n, input int d);
        return (n + d - 1) / d;
    endfunction

endpackage

// File: rtl/gf2_clmul_digit.sv
// rtl/gf2_clmul_digit.sv - carry-less product of a 163-bit operand and one DIGIT-bit slice
module gf2_clmul_digit
    import gf163_pkg::*;
#(
    parameter int DIGIT = 8
) (
    input  logic [M-1:0]       a,
    input  logic [DIGIT-1:0]   d,
    output logic [161+DIGIT:0] p
);

    localparam int W = M - 1 + DIGIT;

    logic [W-1:0] a_ext;

    assign a_ext = W'(a);

    always_comb begin
        p = '0;
        for (int i = 0; i < DIGIT; i++) begin
            p = p ^ ({W{d[i]}} & (a_ext << i));
        end
    end

endmodule

// File: rtl/gf163_digit_mul.sv
// rtl/gf163_digit_mul.sv - digit-serial unreduced GF(2^163) multiplier with valid/ready handshakes
module gf163_digit_mul
    import gf163_pkg::*;
#(
    parameter int DIGIT = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [M-1:0]      a,
    input  logic [M-1:0]      b,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [PROD_W-1:0] product
);

    localparam int NDIG = ceil_div(M, DIGIT);
    localparam int BW   = NDIG * DIGIT;
    localparam int CW   = (NDIG > 1) ? $clog2(NDIG) : 1;

    state_t              state;
    state_t              state_next;
    logic [M-1:0]        a_r;
    logic [BW-1:0]       b_r;
    logic [PROD_W-1:0]   acc;
    logic [CW-1:0]       cnt;
    logic [DIGIT-1:0]    digit;
    logic [161+DIGIT:0]  pp;
    logic                accept;
    logic                last;

    assign in_ready  = (state == ST_IDLE);
    assign out_valid = (state == ST_DONE);
    assign product   = acc;
    assign accept    = in_valid & in_ready;
    assign last      = (cnt == CW'(NDIG - 1));

    // b_r shifts left each RUN cycle, so the top slice is always the next unprocessed digit
    assign digit = b_r[BW-1 -: DIGIT];

    gf2_clmul_digit #(
        .DIGIT(DIGIT)
    ) u_clmul (
        .a(a_r),
        .d(digit),
        .p(pp)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: if (accept) state_next = ST_RUN;
            ST_RUN:  if (last) state_next = ST_DONE;
            ST_DONE: if (out_ready) state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_r <= '0;
            b_r <= '0;
            acc <= '0;
            cnt <= '0;
        end else if (accept) begin
            a_r <= a;
            b_r <= BW'(b);
            acc <= '0;
            cnt <= '0;
        end else if (state == ST_RUN) begin
            // top padding of b_r is zero, so nothing set is ever shifted out of acc
            acc <= (acc << DIGIT) ^ PROD_W'(pp);
            b_r <= b_r << DIGIT;
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: doc/gf163_digit_mul.md
# gf163_digit_mul

Digit-serial carry-less multiplier for GF(2^163) operands. It produces the full 325-bit unreduced product a(x)·b(x), which feeds the `a` input of the combinational polynomial reducer for p(x) = x^163 + x^80 + x^47 + x^9 + 1. Operands enter through a valid/ready handshake, and the product leaves through a second valid/ready handshake. The block sits directly upstream of the reducer in the field-multiplication datapath.

## Interface
- `DIGIT`, default 8: bits of `b` consumed per cycle. Legal range is 1..163.
- `NDIG`, derived as ceil(163/DIGIT), default 21: number of RUN cycles. Not user-overridable.
- `clk` input, 1: single clock, rising-edge.
- `rst_n` input, 1: asynchronous, active-low reset.
- `in_valid` input, 1: operands on `a`/`b` are valid.
- `in_ready` output, 1: block can accept operands.
- `a` input, 163: multiplicand, bit i = coefficient of x^i.
- `b` input, 163: multiplier, same encoding.
- `out_valid` output, 1: `product` is valid.
- `out_ready` input, 1: consumer accepts `product`.
- `product` output, 325: unreduced a·b, bit i = coefficient of x^i.

## Operation
- FSM states:
  - IDLE: `in_ready`=1.
  - RUN: processing digits.
  - DONE: `out_valid`=1.
- FSM transitions:
  - IDLE→RUN on `in_valid & in_ready`. On that edge: latch `a` into `a_r`, latch `b` zero-extended to NDIG·DIGIT bits into `b_r`, clear `acc`, clear `cnt`.
  - RUN: each cycle does `acc <= (acc << DIGIT) ^ clmul(a_r, digit)` and `cnt <= cnt+1`. `digit` is the most-significant unprocessed DIGIT-bit slice of `b_r` (top digit first).
  - RUN→DONE on the edge that processes digit `cnt == NDIG-1`.
  - DONE→IDLE on `out_valid & out_ready`.
- `clmul` is the carry-less (XOR) product of 163×DIGIT bits, with result width 162+DIGIT.
- Width rule: `acc` is 325 bits. The top padding bits of `b_r` are zero, so no set bit is ever shifted out. The final `acc` equals a·b exactly.
- `product` is driven directly from `acc`. It is stable for the whole of DONE and is held until the output handshake.
- `in_valid` in RUN or DONE is ignored: `in_ready`=0 there, and no operand capture happens.
- `out_ready` outside DONE has no effect.
- No accept in the same cycle as the output handshake. The next accept is possible in the cycle after DONE→IDLE.
- Asynchronous reset at any time, including mid-RUN or in DONE:
  - state=IDLE, `acc`=0, `cnt`=0, `a_r`=0, `b_r`=0.
  - Any in-flight result is discarded with no `out_valid` pulse.
- Reset values of outputs: `in_ready`=1, `out_valid`=0, `product`=0.

## Timing
- Accept edge T0. `out_valid` rises after edge T0+NDIG. With DIGIT=8 that is 21 cycles after the accept edge; with DIGIT=1 it is 163.
- Minimum initiation interval is NDIG+2 cycles (accept, NDIG RUN edges, output handshake edge).
- `in_ready` and `out_valid` are registered-state decodes only, with no combinational path from `in_valid`/`out_ready`.
- The critical path is one 163×DIGIT AND-XOR tree plus the 325-bit XOR into `acc`.

## Structure
- Shared package `gf163_pkg` holds:
  - field constants: M=163, PROD_W=325, and the reduction exponents 80, 47, 9;
  - the FSM state enum (IDLE/RUN/DONE);
  - a `ceil_div` function used to derive NDIG.
- One combinational sub-module, `gf2_clmul_digit`: inputs `a`[162:0] and `d`[DIGIT-1:0], output `p`[161+DIGIT:0].
- The top level contains the FSM, counter, operand registers and accumulator.
- Expected RTL size is roughly 150–250 lines in total.

## Test plan
- Identity: a=1, b=1, `out_ready`=1 → `out_valid` 21 cycles after accept, `product`=1 (only bit 0 set), `in_ready` back to 1 one cycle later.
- Top bits: a=x^162, b=x^162 → `product` has only bit 324 set. Then a=all-ones, b=1 → `product`[162:0] all ones, [324:163]=0.
- Back-pressure: a=x^162, b=all-ones, `out_ready` held low for 10 cycles in DONE → `product`[324:162] all ones, [161:0]=0, stable all 10 cycles. A new `in_valid` pulse during that window is not accepted (`in_ready`=0).
- Reset mid-operation: assert `rst_n`=0 at RUN cycle 7 → outputs immediately `in_ready`=1, `out_valid`=0, `product`=0. A fresh a=3, b=3 after release yields `product`=5 (x^2+1).
- Parameter sweep: DIGIT ∈ {1, 8, 163} with 1000 random operand pairs → `product` matches a bit-level software carry-less multiply. Latency is exactly NDIG ∈ {163, 21, 1} cycles.
- Chained with the reducer: random a, b → reducer output equals the software GF(2^163) product modulo p(x).
